dmg_lcd_ctl_p: RTL
==================

# dmg_lcd_ctl_p

Parametrised second-generation DMG LCD timing controller. It generates the dot clock, hsync, vsync, data-latch, control and altsig waveforms for the DMG-style panel from a single system clock, with a programmable dot-clock divider and configurable raster geometry. Pixel data arrives on a valid/ready stream and is buffered in a small FIFO, so the upstream renderer is decoupled from dot timing. The block reports FIFO underflow, and it sits between the pixel renderer and the panel pins.

## Interface
- Parameters:
- CLK_DIV, 2: clk_8m cycles per dot tick. Must be even and ≥2.
- HTOT, 500: last xpos value. A line has HTOT+1 dots.
- VTOT, 170: last ypos value. A frame has VTOT+1 lines.
- HPIX_START, 80: first active dot.
- HPIX_W, 160: active dots per line.
- VPIX_H, 160: active lines, starting at ypos 0.
- HSYNC_START, 62 / HSYNC_END, 78: hsync is high when START ≤ xpos < END.
- HSYNC_CLK, 70: clk is forced high at xpos HSYNC_CLK and HSYNC_CLK+1.
- DLAT_START, 485 / DLAT_END, 501: datal window, also the tail of the control-high window.
- FIFO_DEPTH, 8: pixel FIFO entries. Must be a power of 2, ≥2.
- Ports:
- clk_8m  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable. When low, the block holds in its reset state (synchronous).
- pix_data  in  2  pixel value, DMG shade 0..3.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  FIFO can accept a pixel.
- underflow  out  1  sticky flag: an active dot found the FIFO empty.
- underflow_clr  in  1  clears underflow.
- frame_start  out  1  one-cycle pulse on the tick entering (0,0).
- line_start  out  1  one-cycle pulse on the tick entering xpos 0.
- d0, d1, hsync, vsync, datal, altsig, clk, control  out  1 each  panel pins. All are registered.
- xpos_out  out  9  xpos − HPIX_START, mod 512.
- ypos_out  out  8  ypos.

## Operation
- Divider div_cnt counts 0..CLK_DIV−1. A dot tick occurs when div_cnt = CLK_DIV−1.
- On each tick:
  - xpos advances, wrapping from HTOT to 0.
  - On an xpos wrap, ypos advances, wrapping from VTOT to 0.
  - On a ypos wrap, altsig toggles.
- Active dot: HPIX_START ≤ xpos < HPIX_START+HPIX_W and ypos < VPIX_H.
- clk pin:
  - In an active dot, clk is high while div_cnt ≥ CLK_DIV/2.
  - At xpos HSYNC_CLK and HSYNC_CLK+1, clk is 1.
  - Otherwise clk is 0.
- vsync is 1 while ypos = 0.
- control is 1 when any of the following holds:
  - xpos < 10
  - xpos in 31..34
  - xpos in 181..184
  - xpos in 321..325
  - xpos ≥ DLAT_START
- Pixel FIFO:
  - A push occurs when pix_valid && pix_ready. pix_ready = !full.
  - A pop occurs on the tick that leaves an active dot.
  - A simultaneous push and pop at full is allowed; occupancy is unchanged.
- d0/d1 output:
  - During an active dot, d0/d1 = ~head.
  - If the FIFO is empty during an active dot, d0 = d1 = 1, no pop occurs, and underflow is set.
  - Outside active dots, d0 = d1 = 1.
- underflow_clr and a new underflow in the same cycle: set wins.
- Frame-start flush: the FIFO is flushed on the frame_start tick. pix_ready is 0 in that cycle, so a push attempted in that cycle is dropped.
- en low: div_cnt, xpos, ypos and altsig are forced to 0, the FIFO is flushed, and pix_ready is 0. When en rises, counting restarts from (0,0) and no frame_start pulse is issued for that entry.

## Timing
- Reset values: xpos = ypos = div_cnt = 0, altsig = 0, FIFO empty, underflow = 0.
  - Pins: d0 = d1 = 1; hsync, vsync, datal, clk, control, frame_start, line_start and pix_ready are all 0.
- Output latency: all pins reflect the counters with one clk_8m cycle of latency.
- Period lengths:
  - Line = (HTOT+1)·CLK_DIV cycles.
  - Frame = (VTOT+1) lines.
  - Defaults give 1002 and 171342 cycles.
- Reset mid-frame returns everything to reset values immediately (asynchronous). The pixel in flight is lost.

## Configuration
- DMG_LCD_TESTPAT_EN defined:
  - Adds input test_en (1 bit).
  - With test_en = 1, the active-dot pixel is {xpos_out[4] ^ ypos[4], xpos_out[3] ^ ypos[3]}, giving an 8×8 shade checkerboard.
  - In test mode the FIFO is not popped and underflow is not set. Pushes still work.
- Undefined: no test_en port. Pixels come only from the FIFO.

## Structure
- Package dmg_lcd_pkg holds:
  - typedef dmg_pix_t (logic [1:0]).
  - Control-window constants: 10, 31/34, 181/184, 321/325.
  - Default timing constants.
- Sub-module dmg_lcd_fifo: synchronous FIFO with flush, parametrised depth, dmg_pix_t data, full/empty outputs.

## Test plan
- Reset, then en = 1, no pixels pushed:
  - line_start every 1002 cycles; frame_start every 171342 cycles.
  - hsync high for 32 cycles per line.
  - altsig toggles once per frame.
- Stream of 160·160 pixels, all value 2, kept ahead of consumption:
  - Each active line emits 160 clk pulses with d1 = 0, d0 = 1.
  - underflow stays 0.
- Only 159 pixels supplied for line 0:
  - Dot 160 outputs d0 = d1 = 1 and underflow = 1.
  - underflow_clr pulse returns underflow to 0.
- Hold pix_valid high with no consumption:
  - pix_ready falls after 8 pushes.
  - frame_start flushes the FIFO and pix_ready = 0 in that cycle.
- Drop en at (100,50):
  - Next cycle all pins are at reset values.
  - After en rises, xpos_out = 0x1B0 (0 − 80 mod 512) and ypos_out = 0.
- With DMG_LCD_TESTPAT_EN and test_en = 1, FIFO empty:
  - Dot (80,0) gives d0 = d1 = 1.
  - Dot (88,0) gives d1 = 1, d0 = 0.
  - underflow stays 0.

Source files
------------

// File: rtl/dmg_lcd_pkg.sv
// Shared types and timing constants for the DMG LCD timing controller.
package dmg_lcd_pkg;

  typedef logic [1:0] dmg_pix_t;

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;

  // Fixed control-pin windows inside each line
  localparam int unsigned CTL_HEAD_END = 10;
  localparam int unsigned CTL_A_LO     = 31;
  localparam int unsigned CTL_A_HI     = 34;
  localparam int unsigned CTL_B_LO     = 181;
  localparam int unsigned CTL_B_HI     = 184;
  localparam int unsigned CTL_C_LO     = 321;
  localparam int unsigned CTL_C_HI     = 325;

  localparam int unsigned DEF_CLK_DIV     = 2;
  localparam int unsigned DEF_HTOT        = 500;
  localparam int unsigned DEF_VTOT        = 170;
  localparam int unsigned DEF_HPIX_START  = 80;
  localparam int unsigned DEF_HPIX_W      = 160;
  localparam int unsigned DEF_VPIX_H      = 160;
  localparam int unsigned DEF_HSYNC_START = 62;
  localparam int unsigned DEF_HSYNC_END   = 78;
  localparam int unsigned DEF_HSYNC_CLK   = 70;
  localparam int unsigned DEF_DLAT_START  = 485;
  localparam int unsigned DEF_DLAT_END    = 501;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;

  function automatic logic ctl_window(input logic [XW-1:0] x, input logic [XW-1:0] dlat_start);
    return (x < XW'(CTL_HEAD_END)) ||
           (x >= XW'(CTL_A_LO) && x <= XW'(CTL_A_HI)) ||
           (x >= XW'(CTL_B_LO) && x <= XW'(CTL_B_HI)) ||
           (x >= XW'(CTL_C_LO) && x <= XW'(CTL_C_HI)) ||
           (x >= dlat_start);
  endfunction

endpackage

// File: rtl/dmg_lcd_fifo.sv
// Pixel FIFO with synchronous flush; push at full is accepted when a pop coincides.
module dmg_lcd_fifo
  import dmg_lcd_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  dmg_pix_t wdata,
  input  logic     pop,
  output dmg_pix_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  dmg_pix_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dmg_lcd_ctl_p.sv
// DMG LCD panel timing controller with buffered pixel stream.
// Optional checkerboard test pattern enabled by defining DMG_LCD_TESTPAT_EN.
module dmg_lcd_ctl_p
  import dmg_lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned HTOT        = DEF_HTOT,
  parameter int unsigned VTOT        = DEF_VTOT,
  parameter int unsigned HPIX_START  = DEF_HPIX_START,
  parameter int unsigned HPIX_W      = DEF_HPIX_W,
  parameter int unsigned VPIX_H      = DEF_VPIX_H,
  parameter int unsigned HSYNC_START = DEF_HSYNC_START,
  parameter int unsigned HSYNC_END   = DEF_HSYNC_END,
  parameter int unsigned HSYNC_CLK   = DEF_HSYNC_CLK,
  parameter int unsigned DLAT_START  = DEF_DLAT_START,
  parameter int unsigned DLAT_END    = DEF_DLAT_END,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic          clk_8m,
  input  logic          rst,
  input  logic          en,
  input  dmg_pix_t      pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          underflow,
  input  logic          underflow_clr,
`ifdef DMG_LCD_TESTPAT_EN
  input  logic          test_en,
`endif
  output logic          frame_start,
  output logic          line_start,
  output logic          d0,
  output logic          d1,
  output logic          hsync,
  output logic          vsync,
  output logic          datal,
  output logic          altsig,
  output logic          clk,
  output logic          control,
  output logic [XW-1:0] xpos_out,
  output logic [YW-1:0] ypos_out
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [XW-1:0] XOUT_RST = XW'((1 << XW) - HPIX_START);

  logic [DW-1:0] div_cnt;
  logic [XW-1:0] xpos;
  logic [YW-1:0] ypos;
  logic          run;
  logic          tick_c, xwrap_c, ywrap_c, active_c, fflush_c;
  logic          push_c, pop_c, show_c, uf_set_c, test_c;
  logic          full, empty;
  logic [XW-1:0] xrel_c;
  dmg_pix_t      head, pix_c;

  assign tick_c   = (div_cnt == DW'(CLK_DIV - 1));
  assign xwrap_c  = (xpos == XW'(HTOT));
  assign ywrap_c  = (ypos == YW'(VTOT));
  assign fflush_c = tick_c && xwrap_c && ywrap_c;
  assign xrel_c   = xpos - XW'(HPIX_START);
  assign active_c = (xpos >= XW'(HPIX_START)) && (xpos < XW'(HPIX_START + HPIX_W)) &&
                    (ypos < YW'(VPIX_H));

`ifdef DMG_LCD_TESTPAT_EN
  assign test_c = test_en;
  assign pix_c  = test_en ? {xrel_c[4] ^ ypos[4], xrel_c[3] ^ ypos[3]} : head;
`else
  assign test_c = 1'b0;
  assign pix_c  = head;
`endif

  // run gates pix_ready so it stays low through reset and the first enabled cycle
  assign pix_ready = run && en && !full && !fflush_c;
  assign push_c    = pix_valid && pix_ready;
  assign pop_c     = en && tick_c && active_c && !empty && !test_c;
  assign uf_set_c  = en && active_c && empty && !test_c;
  assign show_c    = active_c && (test_c || !empty);

  dmg_lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_8m),
    .rst   (rst),
    .flush (!en || fflush_c),
    .push  (push_c),
    .wdata (pix_data),
    .pop   (pop_c),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Raster counters
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      xpos    <= '0;
      ypos    <= '0;
      altsig  <= 1'b0;
      run     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      xpos    <= '0;
      ypos    <= '0;
      altsig  <= 1'b0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (tick_c) begin
        div_cnt <= '0;
        xpos    <= xwrap_c ? '0 : xpos + XW'(1);
        if (xwrap_c) ypos <= ywrap_c ? '0 : ypos + YW'(1);
        if (fflush_c) altsig <= ~altsig;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Panel pins, one cycle behind the counters
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst || !en) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      datal       <= 1'b0;
      clk         <= 1'b0;
      control     <= 1'b0;
      d0          <= 1'b1;
      d1          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      xpos_out    <= XOUT_RST;
      ypos_out    <= '0;
    end else begin
      hsync       <= (xpos >= XW'(HSYNC_START)) && (xpos < XW'(HSYNC_END));
      vsync       <= (ypos == '0);
      datal       <= (xpos >= XW'(DLAT_START)) && (xpos < XW'(DLAT_END));
      clk         <= (active_c && (div_cnt >= DW'(CLK_DIV / 2))) ||
                     (xpos == XW'(HSYNC_CLK)) || (xpos == XW'(HSYNC_CLK + 1));
      control     <= ctl_window(xpos, XW'(DLAT_START));
      d0          <= show_c ? ~pix_c[0] : 1'b1;
      d1          <= show_c ? ~pix_c[1] : 1'b1;
      line_start  <= tick_c && xwrap_c;
      frame_start <= fflush_c;
      xpos_out    <= xrel_c;
      ypos_out    <= ypos;
    end
  end

  // Sticky underflow; a new underflow beats a clear
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst)                underflow <= 1'b0;
    else if (uf_set_c)      underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

endmodule
